mem_dbus: RTL and testbench
===========================

# mem_dbus

MEM-stage data-bus access unit of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its register-write fields, ALU op, effective address and store operand. It passes non-memory ops through combinationally to MEM/WB, and executes loads and stores as a handshaked bus transaction. While a transaction is in flight it holds the pipeline via a stall request to the control unit.

## Interface
- TIMEOUT, 255: max REQ cycles without ack before an aborted access (range 2..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- wd_i  in  5  destination register from EX/MEM
- wreg_i  in  1  register write enable from EX/MEM
- wdata_i  in  32  ALU result from EX/MEM
- aluop_i  in  8  ALU op from EX/MEM
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store operand
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  write data to MEM/WB
- stallreq_o  out  1  stall request to pipeline control
- err_o  out  1  one-cycle pulse on bus timeout
- dbus_req_o  out  1  bus request, registered
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}, latched
- dbus_sel_o  out  4  byte lanes, bit 3 = bits 31:24
- dbus_wdata_o  out  32  store data, latched
- dbus_ack_i  in  1  transaction complete; only sampled in REQ
- dbus_rdata_i  in  32  read data, valid with ack

## Operation
- Memory ops, aluop_i: LB 8'b11100000, LBU 11100100, LH 11100001, LHU 11100101, LW 11100011, SB 11101000, SH 11101001, SW 11101011. Any other code is a non-memory op.
- Non-memory op: wd_o/wreg_o/wdata_o = inputs, stallreq_o = 0, FSM stays IDLE.
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- IDLE, memory op present:
  - stallreq_o = 1 combinationally.
  - Latch addr, we, sel, store data, op.
  - Clear counter; next state REQ.
- REQ:
  - dbus_req_o = 1, stallreq_o = 1.
  - On ack: capture dbus_rdata_i, go DONE.
  - Else if counter == TIMEOUT-1: capture 0, set error flag, go DONE.
  - Else counter++.
- DONE:
  - dbus_req_o = 0, stallreq_o = 0.
  - Load result drives wdata_o; err_o = error flag.
  - Next state IDLE unconditionally; EX/MEM advances at the end of this cycle.
- Register outputs during a memory op:
  - wreg_o = 0 while stallreq_o = 1.
  - In DONE, wreg_o = wreg_i and wd_o = wd_i.
  - Stores: wdata_o = wdata_i.
- Byte lanes are big-endian. Store data is replicated.
  - SB: sel = 1000 >> addr[1:0]; data = {4{reg2[7:0]}}.
  - SH: sel = addr[1] ? 0011 : 1100; data = {2{reg2[15:0]}}.
  - SW: sel = 1111.
  - Loads use the same sel; dbus_wdata_o = 0.
- Load extension (byte k = addr[1:0], byte 0 = rdata[31:24]):
  - LB/LBU: sign-/zero-extend the selected byte.
  - LH/LHU: addr[1]=0 → rdata[31:16], else [15:0], then sign-/zero-extend.
  - LW: whole word.
- Misalignment: addr[0] is ignored for halfwords, addr[1:0] for words. No exception is raised.
- Reset values: state IDLE, dbus_req_o 0, dbus_we_o 0, dbus_sel_o 0, dbus_addr_o 0, dbus_wdata_o 0, counter 0, captured data 0, err_o 0. Pass-through outputs follow inputs; a NOP input gives wd_o 0, wreg_o 0, wdata_o 0.

## Timing
- Memory op is first seen in IDLE at cycle N.
  - REQ is entered at N+1.
  - Zero-wait ack at N+1 → DONE at N+2.
  - Minimum occupancy: 3 cycles (2 stalled).
- Each cycle ack is late adds one cycle. Worst case: REQ lasts TIMEOUT cycles.
- Ack and timeout in the same cycle: ack wins, err_o stays 0.
- Ack outside REQ is ignored.
- dbus_addr_o, dbus_sel_o, dbus_we_o and dbus_wdata_o are stable for the whole of REQ.
- rst in any state: IDLE next edge; dbus_req_o drops next edge; an in-flight access is abandoned with no err_o.
- Back-to-back memory ops: DONE → IDLE → new REQ. One IDLE stall cycle between accesses.

## Test plan
- Pass-through: aluop ADD, wd=3, wreg=1, wdata=0x1234 → same on outputs, same cycle; stallreq_o=0; dbus_req_o stays 0.
- LW at 0x00000104, ack at first REQ cycle, rdata=0xDEADBEEF → dbus_addr_o=0x104, sel=1111; stallreq high 2 cycles; DONE wdata_o=0xDEADBEEF, wreg_o=1.
- LB at 0x103, rdata=0x112233F0 → sel=0001, wdata_o=0xFFFFFFF0. LBU at the same address → 0x000000F0.
- SH at 0x202, reg2=0xAAAA5678, ack after 3 wait cycles → we=1, sel=0011, dbus_wdata_o=0x56785678; REQ lasts 4 cycles; wreg_o=0 throughout.
- LW with TIMEOUT=4, ack never asserted → REQ 4 cycles, then DONE with wdata_o=0 and err_o=1 for exactly one cycle. Ack on the 4th REQ cycle → normal completion, err_o=0.
- rst asserted in the 2nd REQ cycle → next cycle dbus_req_o=0, state IDLE; a late ack afterwards causes no output change.

Source files
------------

// File: rtl/mem_dbus.sv
// MEM-stage data-bus unit: passes ALU results through and runs
// loads/stores as a req/ack bus transaction while stalling the pipe.
module mem_dbus #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i
);
    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_op;
    logic [1:0]  r_lo;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_is_mem;
    logic        w_is_store;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_is_mem   = 1'b0;
        w_is_store = 1'b0;
        w_sel      = 4'b1111;
        w_wdata    = 32'h0;
        case (aluop_i)
            OP_LB, OP_LBU: begin
                w_is_mem = 1'b1;
                w_sel    = 4'b1000 >> mem_addr_i[1:0];
            end
            OP_LH, OP_LHU: begin
                w_is_mem = 1'b1;
                w_sel    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: w_is_mem = 1'b1;
            OP_SB: begin
                w_is_mem   = 1'b1;
                w_is_store = 1'b1;
                w_sel      = 4'b1000 >> mem_addr_i[1:0];
                w_wdata    = {4{reg2_i[7:0]}};
            end
            OP_SH: begin
                w_is_mem   = 1'b1;
                w_is_store = 1'b1;
                w_sel      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata    = {2{reg2_i[15:0]}};
            end
            OP_SW: begin
                w_is_mem   = 1'b1;
                w_is_store = 1'b1;
                w_wdata    = reg2_i;
            end
            default: ;
        endcase
    end

    // Big-endian lane pick: byte 0 lives in rdata[31:24]
    always_comb begin
        w_byte = 8'h0;
        case (r_lo)
            2'd0: w_byte = r_rdata[31:24];
            2'd1: w_byte = r_rdata[23:16];
            2'd2: w_byte = r_rdata[15:8];
            2'd3: w_byte = r_rdata[7:0];
            default: ;
        endcase
        w_half = r_lo[1] ? r_rdata[15:0] : r_rdata[31:16];
        w_load = r_rdata;
        case (r_op)
            OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_load = {24'h0, w_byte};
            OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            OP_LHU: w_load = {16'h0, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'h0;
            r_op         <= 8'h0;
            r_lo         <= 2'b00;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'h0;
            dbus_sel_o   <= 4'h0;
            dbus_wdata_o <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        r_state      <= S_REQ;
                        r_cnt        <= 8'h0;
                        r_op         <= aluop_i;
                        r_lo         <= mem_addr_i[1:0];
                        r_err        <= 1'b0;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= w_is_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel_o   <= w_sel;
                        dbus_wdata_o <= w_wdata;
                    end
                end
                S_REQ: begin
                    if (dbus_ack_i) begin
                        r_rdata    <= dbus_rdata_i;
                        r_state    <= S_DONE;
                        dbus_req_o <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata    <= 32'h0;
                        r_err      <= 1'b1;
                        r_state    <= S_DONE;
                        dbus_req_o <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stallreq_o = (r_state == S_REQ) ||
                        (r_state == S_IDLE && w_is_mem);
    assign wd_o    = wd_i;
    assign wreg_o  = stallreq_o ? 1'b0 : wreg_i;
    assign wdata_o = (r_state == S_DONE && !dbus_we_o) ? w_load : wdata_i;
    assign err_o   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_mem_dbus.sv
// Directed bench for mem_dbus: pass-through, loads, stores,
// timeout and reset abandonment, with TIMEOUT=4.
module tb_mem_dbus;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        err_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    mem_dbus #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .err_o(err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o),
        .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observations of one memory transaction
    int          o_stall, o_req, o_wreg_hi, o_unstable;
    logic [31:0] o_wdata, o_addr, o_bwdata;
    logic [3:0]  o_sel;
    logic        o_we, o_wreg, o_err, o_err_after, o_timeout;

    task automatic mem_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] r2, input logic wr,
                          input int ack_at, input logic [31:0] rdata);
        int cyc;
        o_stall = 0; o_req = 0; o_wreg_hi = 0; o_unstable = 0;
        o_timeout = 1'b0;
        aluop_i = op; mem_addr_i = addr; reg2_i = r2;
        wd_i = 5'd7; wreg_i = wr; wdata_i = 32'h5555_0000;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'hBADB_AD00;
        #1;
        cyc = 0;
        while (!(o_stall > 0 && !stallreq_o)) begin
            if (cyc > 300) begin
                o_timeout = 1'b1;
                break;
            end
            if (stallreq_o) begin
                o_stall++;
                if (wreg_o) o_wreg_hi++;
            end
            dbus_ack_i = 1'b0;
            dbus_rdata_i = 32'hBADB_AD00;
            if (dbus_req_o) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = dbus_addr_o; o_sel = dbus_sel_o;
                    o_we = dbus_we_o; o_bwdata = dbus_wdata_o;
                end else if (dbus_addr_o !== o_addr ||
                             dbus_sel_o !== o_sel ||
                             dbus_we_o !== o_we ||
                             dbus_wdata_o !== o_bwdata) begin
                    o_unstable++;
                end
                if (o_req == ack_at) begin
                    dbus_ack_i = 1'b1;
                    dbus_rdata_i = rdata;
                end
            end
            tick();
            cyc++;
        end
        dbus_ack_i = 1'b0;
        o_wdata = wdata_o; o_wreg = wreg_o; o_err = err_o;
        tick();
        aluop_i = 8'h00; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        #1;
        o_err_after = err_o;
    endtask

    task automatic expect_op(input string tag, input int stalls,
                             input int reqs, input logic [31:0] addr,
                             input logic [3:0] sel, input logic we,
                             input logic [31:0] bwd, input logic [31:0] wdo,
                             input logic wro, input logic erro);
        check({tag, " no-hang"}, 32'(o_timeout), 32'd0);
        check({tag, " stalls"}, o_stall, stalls);
        check({tag, " req-cycles"}, o_req, reqs);
        check({tag, " addr"}, o_addr, addr);
        check({tag, " sel"}, 32'(o_sel), 32'(sel));
        check({tag, " we"}, 32'(o_we), 32'(we));
        check({tag, " bus-wdata"}, o_bwdata, bwd);
        check({tag, " bus-stable"}, o_unstable, 0);
        check({tag, " wreg-in-stall"}, o_wreg_hi, 0);
        check({tag, " done-wdata"}, o_wdata, wdo);
        check({tag, " done-wreg"}, 32'(o_wreg), 32'(wro));
        check({tag, " done-err"}, 32'(o_err), 32'(erro));
        check({tag, " err-after"}, 32'(o_err_after), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; aluop_i = 8'h00;
        mem_addr_i = 32'h0; reg2_i = 32'h0;
        dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst req", 32'(dbus_req_o), 32'd0);
        check("rst we", 32'(dbus_we_o), 32'd0);
        check("rst sel", 32'(dbus_sel_o), 32'd0);
        check("rst addr", dbus_addr_o, 32'h0);
        check("rst bwdata", dbus_wdata_o, 32'h0);
        check("rst wdata_o", wdata_o, 32'h0);
        check("rst wreg_o", 32'(wreg_o), 32'd0);
        check("rst wd_o", 32'(wd_o), 32'd0);
        check("rst stall", 32'(stallreq_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);

        aluop_i = 8'b00100000; wd_i = 5'd3; wreg_i = 1'b1;
        wdata_i = 32'h1234;
        #1;
        check("pt wd", 32'(wd_o), 32'd3);
        check("pt wreg", 32'(wreg_o), 32'd1);
        check("pt wdata", wdata_o, 32'h1234);
        check("pt stall", 32'(stallreq_o), 32'd0);
        tick();
        check("pt req", 32'(dbus_req_o), 32'd0);
        check("pt stall2", 32'(stallreq_o), 32'd0);

        mem_op(8'b11100011, 32'h104, 32'h0, 1'b1, 1, 32'hDEADBEEF);
        expect_op("lw", 2, 1, 32'h104, 4'b1111, 1'b0, 32'h0,
                  32'hDEADBEEF, 1'b1, 1'b0);
        mem_op(8'b11100000, 32'h103, 32'h0, 1'b1, 1, 32'h112233F0);
        expect_op("lb", 2, 1, 32'h100, 4'b0001, 1'b0, 32'h0,
                  32'hFFFFFFF0, 1'b1, 1'b0);
        mem_op(8'b11100100, 32'h103, 32'h0, 1'b1, 1, 32'h112233F0);
        expect_op("lbu", 2, 1, 32'h100, 4'b0001, 1'b0, 32'h0,
                  32'h000000F0, 1'b1, 1'b0);
        mem_op(8'b11100001, 32'h102, 32'h0, 1'b1, 2, 32'h12348765);
        expect_op("lh", 3, 2, 32'h100, 4'b0011, 1'b0, 32'h0,
                  32'hFFFF8765, 1'b1, 1'b0);
        mem_op(8'b11100101, 32'h101, 32'h0, 1'b1, 1, 32'h87651234);
        expect_op("lhu", 2, 1, 32'h100, 4'b1100, 1'b0, 32'h0,
                  32'h00008765, 1'b1, 1'b0);
        mem_op(8'b11101001, 32'h202, 32'hAAAA5678, 1'b0, 4, 32'h0);
        expect_op("sh", 5, 4, 32'h200, 4'b0011, 1'b1, 32'h56785678,
                  32'h5555_0000, 1'b0, 1'b0);
        mem_op(8'b11101000, 32'h201, 32'h000000AB, 1'b0, 1, 32'h0);
        expect_op("sb", 2, 1, 32'h200, 4'b0100, 1'b1, 32'hABABABAB,
                  32'h5555_0000, 1'b0, 1'b0);
        mem_op(8'b11101011, 32'h30E, 32'hCAFEF00D, 1'b0, 1, 32'h0);
        expect_op("sw", 2, 1, 32'h30C, 4'b1111, 1'b1, 32'hCAFEF00D,
                  32'h5555_0000, 1'b0, 1'b0);
        mem_op(8'b11100011, 32'h400, 32'h0, 1'b1, 0, 32'h0);
        expect_op("lw-timeout", 5, 4, 32'h400, 4'b1111, 1'b0, 32'h0,
                  32'h0, 1'b1, 1'b1);
        mem_op(8'b11100011, 32'h400, 32'h0, 1'b1, 4, 32'h01020304);
        expect_op("lw-ack-last", 5, 4, 32'h400, 4'b1111, 1'b0, 32'h0,
                  32'h01020304, 1'b1, 1'b0);

        // Reset during the second REQ cycle abandons the access
        aluop_i = 8'b11100011; mem_addr_i = 32'h300; wreg_i = 1'b1;
        wd_i = 5'd9; wdata_i = 32'h77;
        #1;
        tick();
        check("rst-mid req1", 32'(dbus_req_o), 32'd1);
        tick();
        check("rst-mid req2", 32'(dbus_req_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aluop_i = 8'h00; wdata_i = 32'h99;
        #1;
        check("rst-mid req", 32'(dbus_req_o), 32'd0);
        check("rst-mid stall", 32'(stallreq_o), 32'd0);
        check("rst-mid err", 32'(err_o), 32'd0);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFEEDFACE;
        tick();
        dbus_ack_i = 1'b0;
        #1;
        check("late-ack wdata", wdata_o, 32'h99);
        check("late-ack req", 32'(dbus_req_o), 32'd0);
        check("late-ack err", 32'(err_o), 32'd0);
        check("late-ack stall", 32'(stallreq_o), 32'd0);
        tick();
        check("late-ack idle", 32'(dbus_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
